// File: rtl/ak16_pkg.sv
// Shared definitions for the AK16 execute pipeline: forwarding select codes,
// default datapath width and the EX1 operand-buffer state encoding.
package ak16_pkg;

    localparam int FWD_REGFILE    = 0;
    localparam int FWD_EXMEM      = 1;
    localparam int FWD_MEMWB      = 2;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Selects one source operand from the register file or one of the
// forwarding result buses; out-of-range selects fall back to register file.
module operand_fwd_mux
    import ak16_pkg::*;
#(
    parameter  int DATA_W  = DEFAULT_DATA_W,
    parameter  int NUM_FWD = 2,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]         operand
);

    always_comb begin
        operand = rf_data;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (sel == SEL_W'(k)) begin
                operand = fwd_data[(k-1)*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/ex1_operand_buffer.sv
// EX1 operand stage: resolves forwarded ALU operands and store data, then
// holds them in a 2-entry skid buffer so EX2 stalls never re-sample the buses.
module ex1_operand_buffer
    import ak16_pkg::*;
#(
    parameter  int DATA_W  = DEFAULT_DATA_W,
    parameter  int NUM_FWD = 2,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         ex_rs1_data,
    input  logic [DATA_W-1:0]         ex_rs2_data,
    input  logic [DATA_W-1:0]         ex_imm,
    input  logic                      ex_alu_src,
    input  logic [SEL_W-1:0]          forward_a,
    input  logic [SEL_W-1:0]          forward_b,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         alu_in1,
    output logic [DATA_W-1:0]         alu_in2,
    output logic [DATA_W-1:0]         store_data,
    output logic [15:0]               fwd_hazard_cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    buf_state_t        state, state_nxt;
    logic              accept, hazard;
    logic              load_main_in, load_main_skid, load_skid;
    logic [DATA_W-1:0] src_a_p0, src_b_p0, opb_p0;
    logic [DATA_W-1:0] main_a_p1, main_b_p1, main_st_p1;
    logic [DATA_W-1:0] skid_a_p1, skid_b_p1, skid_st_p1;

    assign accept = in_valid && in_ready;
    assign hazard = (forward_a != SEL_W'(FWD_REGFILE)) || (forward_b != SEL_W'(FWD_REGFILE));

    // Stage p0: combinational operand resolution
    operand_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd_a (
        .sel      (forward_a),
        .rf_data  (ex_rs1_data),
        .fwd_data (fwd_data),
        .operand  (src_a_p0)
    );

    operand_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd_b (
        .sel      (forward_b),
        .rf_data  (ex_rs2_data),
        .fwd_data (fwd_data),
        .operand  (src_b_p0)
    );

    assign opb_p0 = ex_alu_src ? ex_imm : src_b_p0;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (out_ready && accept) begin
                    load_main_in = 1'b1;
                end else if (out_ready) begin
                    state_nxt = BUF_EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (out_ready) begin
                    load_main_skid = 1'b1;
                    state_nxt      = BUF_ONE;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
        if (flush) begin
            state_nxt      = BUF_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Stage p1: main (visible) and skid (hidden) entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BUF_EMPTY;
            in_ready   <= 1'b1;
            main_a_p1  <= '0;
            main_b_p1  <= '0;
            main_st_p1 <= '0;
            skid_a_p1  <= '0;
            skid_b_p1  <= '0;
            skid_st_p1 <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != BUF_FULL);
            if (flush) begin
                main_a_p1  <= '0;
                main_b_p1  <= '0;
                main_st_p1 <= '0;
                skid_a_p1  <= '0;
                skid_b_p1  <= '0;
                skid_st_p1 <= '0;
            end else begin
                if (load_main_in) begin
                    main_a_p1  <= src_a_p0;
                    main_b_p1  <= opb_p0;
                    main_st_p1 <= src_b_p0;
                end else if (load_main_skid) begin
                    main_a_p1  <= skid_a_p1;
                    main_b_p1  <= skid_b_p1;
                    main_st_p1 <= skid_st_p1;
                end
                if (load_skid) begin
                    skid_a_p1  <= src_a_p0;
                    skid_b_p1  <= opb_p0;
                    skid_st_p1 <= src_b_p0;
                end
            end
        end
    end

    // The hazard counter survives flushes; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_hazard_cnt <= 16'h0000;
        end else if (!flush && accept && hazard) begin
            fwd_hazard_cnt <= sat_inc(fwd_hazard_cnt);
        end
    end

    assign out_valid  = (state != BUF_EMPTY);
    assign alu_in1    = main_a_p1;
    assign alu_in2    = main_b_p1;
    assign store_data = main_st_p1;

endmodule

// File: tb/tb_ex1_operand_buffer.sv
// Scoreboard bench for ex1_operand_buffer: expected entries are queued at
// accept time from a reference model and popped when EX2 consumes them.
module tb_ex1_operand_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ex_rs1_data;
    logic [15:0] ex_rs2_data;
    logic [15:0] ex_imm;
    logic        ex_alu_src;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [15:0] store_data;
    logic [15:0] fwd_hazard_cnt;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] st;
    } ent_t;

    ent_t        sb[$];
    ent_t        got;
    logic [15:0] exp_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;

    ex1_operand_buffer #(.DATA_W(16), .NUM_FWD(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_alu_src     (ex_alu_src),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .fwd_data       (fwd_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_in1        (alu_in1),
        .alu_in2        (alu_in2),
        .store_data     (store_data),
        .fwd_hazard_cnt (fwd_hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_sel(input logic [1:0] sel, input logic [15:0] rf,
                                            input logic [31:0] fwd);
        if (sel == 2'd1) return fwd[15:0];
        if (sel == 2'd2) return fwd[31:16];
        return rf;
    endfunction

    // Inputs are stable at the falling edge; pop what EX2 takes, queue what is accepted.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            exp_cnt = 16'h0000;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_unexpected", {31'b0, out_valid}, 32'd0);
                end else begin
                    got = sb.pop_front();
                    check_val("sb_alu_in1", {16'b0, alu_in1}, {16'b0, got.a});
                    check_val("sb_alu_in2", {16'b0, alu_in2}, {16'b0, got.b});
                    check_val("sb_store", {16'b0, store_data}, {16'b0, got.st});
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                got.a  = ref_sel(forward_a, ex_rs1_data, fwd_data);
                got.st = ref_sel(forward_b, ex_rs2_data, fwd_data);
                got.b  = ex_alu_src ? ex_imm : got.st;
                sb.push_back(got);
                if ((forward_a != 2'd0 || forward_b != 2'd0) && exp_cnt != 16'hFFFF)
                    exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    task automatic drive(input logic [1:0] fa, input logic [1:0] fb, input logic src,
                         input logic [15:0] rs1, input logic [15:0] rs2, input logic [15:0] imm);
        forward_a   = fa;
        forward_b   = fb;
        ex_alu_src  = src;
        ex_rs1_data = rs1;
        ex_rs2_data = rs2;
        ex_imm      = imm;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ex_rs1_data = '0; ex_rs2_data = '0; ex_imm = '0; ex_alu_src = 1'b0;
        forward_a = '0; forward_b = '0; fwd_data = '0;

        // Reset state, then idle after release
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_val("rst_cnt", {16'b0, fwd_hazard_cnt}, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("idle_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("idle_in_ready", {31'b0, in_ready}, 32'd1);
        check_val("idle_alu_in1", {16'b0, alu_in1}, 32'h0);
        check_val("idle_alu_in2", {16'b0, alu_in2}, 32'h0);
        check_val("idle_store", {16'b0, store_data}, 32'h0);

        // Forwarding with out_ready high
        fwd_data = {16'hBBBB, 16'hAAAA};
        drive(2'd2, 2'd1, 1'b0, 16'h1111, 16'h2222, 16'h0000);
        check_val("fwd1_valid", {31'b0, out_valid}, 32'd1);
        check_val("fwd1_alu_in1", {16'b0, alu_in1}, 32'hBBBB);
        check_val("fwd1_alu_in2", {16'b0, alu_in2}, 32'hAAAA);
        check_val("fwd1_cnt", {16'b0, fwd_hazard_cnt}, 32'd1);
        drive(2'd2, 2'd1, 1'b1, 16'h1111, 16'h2222, 16'h0004);
        check_val("imm_alu_in2", {16'b0, alu_in2}, 32'h0004);
        check_val("imm_store", {16'b0, store_data}, 32'hAAAA);
        drive(2'd3, 2'd0, 1'b0, 16'h1111, 16'h2222, 16'h0000);
        check_val("oor_alu_in1", {16'b0, alu_in1}, 32'h1111);
        check_val("oor_cnt", {16'b0, fwd_hazard_cnt}, {16'b0, exp_cnt});
        @(posedge clk);
        #1;

        // Back-pressure: fill main and skid, then drain
        out_ready = 1'b0;
        drive(2'd0, 2'd0, 1'b0, 16'h0001, 16'h0101, 16'h0000);
        check_val("bp_in_ready_one", {31'b0, in_ready}, 32'd1);
        drive(2'd0, 2'd0, 1'b0, 16'h0002, 16'h0202, 16'h0000);
        check_val("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
        fwd_data = {16'h5A5A, 16'hC3C3};
        ex_rs1_data = 16'hDEAD;
        ex_rs2_data = 16'hBEEF;
        repeat (2) @(posedge clk);
        #1;
        check_val("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        check_val("bp_hold_alu_in1", {16'b0, alu_in1}, 32'h0001);
        check_val("bp_hold_store", {16'b0, store_data}, 32'h0101);
        check_val("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_drain_alu_in1", {16'b0, alu_in1}, 32'h0002);
        check_val("bp_drain_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check_val("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush while FULL with a new instruction presented
        out_ready = 1'b0;
        drive(2'd0, 2'd0, 1'b0, 16'h0005, 16'h0000, 16'h0000);
        drive(2'd0, 2'd0, 1'b0, 16'h0006, 16'h0000, 16'h0000);
        ex_rs1_data = 16'h0003;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check_val("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("flush_no_output", {31'b0, out_valid}, 32'd0);
        check_val("flush_cnt_kept", {16'b0, fwd_hazard_cnt}, {16'b0, exp_cnt});

        // Asynchronous reset in the middle of a cycle while FULL
        out_ready = 1'b0;
        drive(2'd1, 2'd0, 1'b0, 16'h0007, 16'h0000, 16'h0000);
        drive(2'd1, 2'd2, 1'b0, 16'h0008, 16'h0000, 16'h0000);
        check_val("pre_rst_full", {31'b0, in_ready}, 32'd0);
        check_val("pre_rst_cnt", {16'b0, fwd_hazard_cnt}, {16'b0, exp_cnt});
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_val("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("arst_alu_in1", {16'b0, alu_in1}, 32'h0);
        check_val("arst_store", {16'b0, store_data}, 32'h0);
        check_val("arst_cnt", {16'b0, fwd_hazard_cnt}, 32'd0);
        check_val("arst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;

        // Saturation run with randomised data and rs2 selects
        for (int i = 0; i < 70000; i++) begin
            ex_rs1_data = 16'($urandom);
            ex_rs2_data = 16'($urandom);
            ex_imm      = 16'($urandom);
            fwd_data    = $urandom;
            forward_a   = 2'd1;
            forward_b   = 2'($urandom_range(0, 3));
            ex_alu_src  = 1'($urandom_range(0, 1));
            in_valid    = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_val("sat_cnt", {16'b0, fwd_hazard_cnt}, 32'h0000FFFF);
        check_val("sat_model_cnt", {16'b0, fwd_hazard_cnt}, {16'b0, exp_cnt});
        repeat (2) @(posedge clk);
        #1;
        check_val("sat_drained", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex1_operand_buffer.md
Name: ex1_operand_buffer

Overview:
Parametrised successor to the EX1 operand stage. It resolves the ALU operands and the store data for one instruction per cycle:
- each source operand is forwarded from one of NUM_FWD later-stage result buses, or taken from register-file data;
- the immediate is then optionally substituted on operand B.

The resolved operands are captured into a 2-entry skid buffer with a valid/ready handshake, so that EX2 back-pressure never re-resolves forwarding against stale buses. It sits between the ID/EX register and the EX2/ALU stage.

Parameters:
- DATA_W, 16, datapath width in bits.
- NUM_FWD, 2, number of forwarding source buses. Index 0 = EX/MEM, 1 = MEM/WB, further indices = deeper stages. Legal range 1..6.
- SEL_W, $clog2(NUM_FWD+1), forwarding-select width. Derived; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush (branch mispredict / trap).
- in_valid  in  1  ID/EX presents a valid instruction.
- in_ready  out  1  buffer can accept this cycle. Registered.
- ex_rs1_data  in  DATA_W  register-file value of rs1.
- ex_rs2_data  in  DATA_W  register-file value of rs2.
- ex_imm  in  DATA_W  sign-extended immediate.
- ex_alu_src  in  1  0 = operand B from rs2 path, 1 = immediate.
- forward_a  in  SEL_W  rs1 source: 0 = register file, k = fwd_data slice k-1.
- forward_b  in  SEL_W  rs2 source, same encoding.
- fwd_data  in  NUM_FWD*DATA_W  forwarding buses; slice k is [k*DATA_W +: DATA_W].
- out_valid  out  1  alu_in1/alu_in2/store_data hold a valid instruction.
- out_ready  in  1  EX2 consumes the output this cycle.
- alu_in1  out  DATA_W  resolved operand A.
- alu_in2  out  DATA_W  resolved operand B (immediate when ex_alu_src = 1).
- store_data  out  DATA_W  forwarded rs2 value, independent of ex_alu_src.
- fwd_hazard_cnt  out  16  saturating count of accepted instructions with forward_a != 0 or forward_b != 0.

Behaviour:
Reset (rst low, asynchronous):
- out_valid = 0; skid entry empty.
- alu_in1, alu_in2, store_data = 0.
- in_ready = 1, but in_valid is ignored while rst is low.
- fwd_hazard_cnt = 0.

Operand resolution (combinational, evaluated only in the accept cycle, accept = in_valid && in_ready):
- src_a = forward_a == 0 ? ex_rs1_data : fwd_data slice (forward_a-1).
- src_b = the same rule using forward_b and ex_rs2_data.
- A select value > NUM_FWD resolves to register-file data.
- Entry captured = {src_a, ex_alu_src ? ex_imm : src_b, src_b}.

Buffer states (main register drives the outputs; skid is the hidden second entry):
- EMPTY: out_valid = 0. On accept, capture into main → ONE.
- ONE:
  - out_ready && accept → main reloads with the new entry; stay in ONE.
  - out_ready && !accept → EMPTY.
  - !out_ready && accept → entry goes to skid → FULL.
- FULL: in_ready = 0 from the next edge. On out_ready, skid moves to main → ONE and in_ready returns to 1 on the following cycle.

Timing and ordering:
- Latency: 1 cycle from accept to out_valid when the buffer is EMPTY.
- Throughput: 1 per cycle while out_ready stays high.
- in_ready = !skid_valid, registered.
- Output data and out_valid are held stable while out_valid && !out_ready.
- Order is strictly FIFO; the skid entry is never overtaken.

Flush:
- Flush has priority over everything else: main and skid are cleared and out_valid = 0 next edge; in_ready = 1 next edge.
- An in_valid presented in the flush cycle is dropped.
- fwd_hazard_cnt is not cleared by flush.

Counter:
- fwd_hazard_cnt increments on each non-flushed accept with a non-zero select.
- It saturates at 0xFFFF.

Decomposition:
- Shared package ak16_pkg holds:
  - FWD_REGFILE = 0, FWD_EXMEM = 1, FWD_MEMWB = 2;
  - default DATA_W = 16;
  - buffer state encoding EMPTY/ONE/FULL.
- One sub-module, operand_fwd_mux (parameters DATA_W, NUM_FWD), is instantiated twice: once for rs1 and once for rs2.

Test Plan:
1. Reset then idle: release rst with in_valid = 0 → out_valid = 0, in_ready = 1, all outputs 0x0000.
2. Forwarding, NUM_FWD = 2, out_ready = 1: rs1 = 0x1111, rs2 = 0x2222, fwd slice0 = 0xAAAA, slice1 = 0xBBBB.
   - forward_a = 2, forward_b = 1, alu_src = 0 → next cycle alu_in1 = 0xBBBB, alu_in2 = 0xAAAA, store_data = 0xAAAA, fwd_hazard_cnt = 1.
   - Repeat with alu_src = 1, imm = 0x0004 → alu_in2 = 0x0004, store_data = 0xAAAA.
   - forward_a = 3 → alu_in1 = 0x1111.
3. Back-pressure: hold out_ready = 0 and accept two instructions (A1 = 0x0001, A1 = 0x0002).
   - in_ready drops to 0 after the second accept.
   - The forwarding buses change afterwards → held outputs unchanged.
   - Assert out_ready → 0x0001 then 0x0002 emerge on consecutive cycles, and in_ready returns to 1.
4. Flush while FULL with in_valid = 1 (A1 = 0x0003) → out_valid = 0 next cycle, 0x0003 never appears, in_ready = 1.
5. Asynchronous reset asserted mid-cycle while FULL → outputs clear immediately without waiting for a clock edge; fwd_hazard_cnt = 0.
6. 70000 accepts, each with forward_a = 1 → fwd_hazard_cnt saturates at 0xFFFF.
